// File: rtl/clk_en_mgr.sv
// Clock-enable manager behind the board PLL: qualifies PLL lock, drives a downstream
// synchronous reset and produces per-channel enable pulses and 50%-duty divided strobes.
module clk_en_mgr #(
   parameter int  NUM_CH    = 4,
   parameter int  DIV_W     = 8,
   parameter int  LOCK_CNT  = 1024,
   parameter int  DIV_RESET = 1,
   localparam int CH_W      = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
   input  logic              clkin,
   input  logic              reset,
   input  logic              lock_i,
   input  logic              cfg_valid,
   output logic              cfg_ready,
   input  logic [CH_W-1:0]   cfg_ch,
   input  logic [DIV_W-1:0]  cfg_div,
   output logic              locked_o,
   output logic              rst_o,
   output logic [NUM_CH-1:0] ce_o,
   output logic [NUM_CH-1:0] div_o,
   output logic [7:0]        loss_cnt_o
);

   localparam int QCNT_W = (LOCK_CNT > 1) ? $clog2(LOCK_CNT) : 1;
   localparam logic [QCNT_W-1:0] QCNT_LAST = QCNT_W'(LOCK_CNT - 1);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_QUAL = 2'd1,
      ST_RUN  = 2'd2
   } state_t;

   state_t            state_reg, state_next;
   logic [QCNT_W-1:0] qcnt_reg, qcnt_next;
   logic [7:0]        loss_reg, loss_next;
   logic              lock_meta_reg, lock_s_reg;
   logic              locked_reg, rst_reg;
   logic              run_stay;
   logic              pend_sel;
   logic              cfg_fire;
   logic [NUM_CH-1:0] pend_flags;
   logic [NUM_CH-1:0] ce_bits;
   logic [NUM_CH-1:0] div_bits;

   // lock_i is asynchronous to clkin
   always_ff @(posedge clkin) begin
      if (reset) begin
         lock_meta_reg <= 1'b0;
         lock_s_reg    <= 1'b0;
      end else begin
         lock_meta_reg <= lock_i;
         lock_s_reg    <= lock_meta_reg;
      end
   end

   always_ff @(posedge clkin) begin
      if (reset) begin
         state_reg  <= ST_IDLE;
         qcnt_reg   <= '0;
         loss_reg   <= '0;
         locked_reg <= 1'b0;
         rst_reg    <= 1'b1;
      end else begin
         state_reg  <= state_next;
         qcnt_reg   <= qcnt_next;
         loss_reg   <= loss_next;
         locked_reg <= (state_next == ST_RUN);
         rst_reg    <= (state_next != ST_RUN);
      end
   end

   always_comb begin
      state_next = state_reg;
      qcnt_next  = qcnt_reg;
      loss_next  = loss_reg;
      case (state_reg)
         ST_IDLE: begin
            if (lock_s_reg) begin
               state_next = ST_QUAL;
               qcnt_next  = '0;
            end
         end
         ST_QUAL: begin
            if (!lock_s_reg) begin
               state_next = ST_IDLE;
            end else if (qcnt_reg == QCNT_LAST) begin
               state_next = ST_RUN;
            end else begin
               qcnt_next = qcnt_reg + QCNT_W'(1);
            end
         end
         ST_RUN: begin
            if (!lock_s_reg) begin
               state_next = ST_IDLE;
               if (loss_reg != 8'hFF) begin
                  loss_next = loss_reg + 8'd1;
               end
            end
         end
         default: begin
            state_next = ST_IDLE;
         end
      endcase
   end

   // Channels count only on edges where RUN is both current and next state
   assign run_stay = (state_reg == ST_RUN) && lock_s_reg;

   always_comb begin
      pend_sel = 1'b0;
      for (int i = 0; i < NUM_CH; i++) begin
         if (cfg_ch == CH_W'(i)) begin
            pend_sel = pend_flags[i];
         end
      end
   end

   assign cfg_ready = ~reset & ~pend_sel;
   assign cfg_fire  = cfg_valid & cfg_ready;

   for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
      logic [DIV_W-1:0] div_reg, div_next;
      logic [DIV_W-1:0] pend_reg, pend_next;
      logic [DIV_W-1:0] cnt_reg, cnt_next;
      logic             pend_valid_reg, pend_valid_next;
      logic             ce_reg, ce_next;
      logic             tog_reg, tog_next;
      logic             wr_en;

      assign wr_en = cfg_fire && (cfg_ch == CH_W'(gi));

      always_comb begin
         div_next        = div_reg;
         pend_next       = pend_reg;
         pend_valid_next = pend_valid_reg;
         cnt_next        = cnt_reg;
         ce_next         = 1'b0;
         tog_next        = tog_reg;
         if (run_stay) begin
            if (cnt_reg == div_reg) begin
               ce_next  = 1'b1;
               cnt_next = '0;
               tog_next = ~tog_reg;
               if (pend_valid_reg) begin
                  div_next        = pend_reg;
                  pend_valid_next = 1'b0;
               end
            end else begin
               cnt_next = cnt_reg + DIV_W'(1);
            end
            // A write landing on the terminal count waits for the next one
            if (wr_en) begin
               pend_next       = cfg_div;
               pend_valid_next = 1'b1;
            end
         end else begin
            cnt_next = '0;
            tog_next = 1'b0;
            if (pend_valid_reg) begin
               div_next        = pend_reg;
               pend_valid_next = 1'b0;
            end
            if (wr_en) begin
               div_next = cfg_div;
            end
         end
      end

      always_ff @(posedge clkin) begin
         if (reset) begin
            div_reg        <= DIV_W'(DIV_RESET);
            pend_reg       <= '0;
            pend_valid_reg <= 1'b0;
            cnt_reg        <= '0;
            ce_reg         <= 1'b0;
            tog_reg        <= 1'b0;
         end else begin
            div_reg        <= div_next;
            pend_reg       <= pend_next;
            pend_valid_reg <= pend_valid_next;
            cnt_reg        <= cnt_next;
            ce_reg         <= ce_next;
            tog_reg        <= tog_next;
         end
      end

      assign pend_flags[gi] = pend_valid_reg;
      assign ce_bits[gi]    = ce_reg;
      assign div_bits[gi]   = tog_reg;
   end

   assign ce_o       = ce_bits;
   assign div_o      = div_bits;
   assign locked_o   = locked_reg;
   assign rst_o      = rst_reg;
   assign loss_cnt_o = loss_reg;

endmodule

// File: doc/clk_en_mgr.md
# clk_en_mgr

Multi-channel clock-enable manager that sits directly behind the board PLL. It runs in the PLL output clock domain and qualifies the PLL lock signal. It then drives a synchronous reset for downstream logic and generates NUM_CH independently programmable clock-enable pulses plus 50 %-duty divided strobes. Divisors can be changed at runtime through a ready/valid port without glitches.

## Interface
- NUM_CH, 4: number of divider channels (1..8).
- DIV_W, 8: divisor width per channel.
- LOCK_CNT, 1024: consecutive synchronized-lock cycles required before release (>=2).
- DIV_RESET, 1: divisor loaded into every channel on reset.

- clkin  in  1  PLL output clock; all logic on rising edge.
- reset  in  1  synchronous, active-high.
- lock_i  in  1  raw PLL lock; asynchronous, double-flopped internally.
- cfg_valid  in  1  divisor write request.
- cfg_ready  out  1  write can be accepted this cycle.
- cfg_ch  in  clog2(NUM_CH) (min 1)  target channel; values >= NUM_CH are accepted and ignored.
- cfg_div  in  DIV_W  new divisor value D; enable period is D+1 cycles.
- locked_o  out  1  high only in RUN.
- rst_o  out  1  downstream synchronous reset; equals ~locked_o.
- ce_o  out  NUM_CH  one-cycle enable pulse per channel.
- div_o  out  NUM_CH  toggle strobe per channel, period 2(D+1).
- loss_cnt_o  out  8  saturating count of RUN->IDLE lock losses.

## Operation
- Sync: lock_s = lock_i delayed through 2 flops.
- FSM states:
  - IDLE: wait for lock_s=1, then go to QUAL with qcnt=0.
  - QUAL: if lock_s=0, go to IDLE. Else if qcnt==LOCK_CNT-1, go to RUN. Else qcnt++.
  - RUN: if lock_s=0, go to IDLE and increment loss_cnt_o (saturates at 255).
- Channels:
  - Outside RUN: cnt=0, ce_o=0, div_o=0.
  - In RUN, per channel each cycle: if cnt==div, set ce_o=1, cnt=0 and toggle div_o. If a pending value exists, move it into div and clear pending. Otherwise cnt++ and ce_o=0.
- Config:
  - cfg_ready = ~reset & ~pending_valid[cfg_ch]; always 1 for an out-of-range cfg_ch.
  - Transfer occurs when cfg_valid & cfg_ready.
  - Outside RUN, a transfer writes div directly.
  - In RUN, a transfer writes the pending slot, which is applied at that channel's next terminal count.
- Divisors and loss_cnt_o survive lock loss. Only reset restores them, to DIV_RESET and 0 respectively.
- Transfer in the same cycle as that channel's terminal count: the value goes to pending and is applied at the following terminal count, never the current one.
- Lock loss in the same cycle as QUAL terminal count: go to IDLE.
- Lock loss in RUN: pending values are committed to div immediately on entering IDLE.
- D=0: ce_o is held high every RUN cycle; div_o toggles every cycle.

## Timing
- Reset values:
  - state IDLE, qcnt 0, lock sync flops 0.
  - locked_o 0, rst_o 1, ce_o 0, div_o 0, loss_cnt_o 0.
  - cfg_ready 0 while reset is high.
  - pending cleared, all div = DIV_RESET.
- Reset mid-operation overrides everything on the next edge.
- Lock release latency: if lock_i is first sampled high at edge k and stays high, locked_o=1 and rst_o=0 after edge k+2+LOCK_CNT.
- Lock drop latency: if lock_i is sampled low at edge m in RUN, locked_o=0, rst_o=1, and ce_o/div_o are forced to 0 after edge m+2.
- Channel start: entering RUN at edge R, the first ce_o pulse follows edge R+D+1, then one pulse every D+1 cycles.
- All outputs are registered; no combinational path from lock_i.

## Test plan
- **Lock release:** LOCK_CNT=16; reset, then lock_i=1 at edge 10 -> rst_o falls after edge 28, and loss_cnt_o=0.
- **Lock glitch:** lock_i high 10 cycles, low 1 cycle, high again -> qualification restarts; release occurs 18 cycles after the re-rise; locked_o never pulses.
- **Divider rates:** divisors ch0=0, ch1=1, ch2=4, ch3=255 in RUN -> ce_o periods 1/2/5/256 and div_o periods 2/4/10/512 over 2048 cycles; all channels phase-aligned at RUN entry.
- **Runtime update:** ch2 D=4, write D=2 mid-period, then a second write -> cfg_ready stays low until the terminal count; the old period completes (5), then the period becomes 3; no short or double ce_o.
- **Collision:** write coinciding with ch1's terminal count -> the current ch1 period is unaffected; the new value takes effect one period later.
- **Lock loss and reset:** drop lock_i in RUN -> ce_o/div_o are 0 and rst_o=1 two cycles later, loss_cnt_o=1. After re-lock the divisors are retained. Asserting reset mid-RUN -> all outputs return to reset values on the next edge, and divisors revert to DIV_RESET.
